// File: rtl/serial_addsub4_if.sv
// Handshake and operand/result bundle between a requester and serial_addsub4.
// The requester takes the master side; the serial adder/subtractor takes the slave side.
interface serial_addsub4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b_c;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, a, b_c, cin,
    input  busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, a, b_c, cin,
    output busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/serial_addsub4.sv
// Bit-serial adder/subtractor: LSB-first ripple over WIDTH clocks with start/done
// handshake, then registers sum with carry, signed-overflow and zero flags.
module serial_addsub4 #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_addsub4_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             busy_q;
  logic             done_q;

  logic             s_d;
  logic             c_d;
  logic [WIDTH-1:0] res_d;
  logic             last_d;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  always_comb begin
    s_d    = a_q[0] ^ b_q[0] ^ c_q;
    c_d    = maj3(a_q[0], b_q[0], c_q);
    res_d  = {s_d, res_q[WIDTH-1:1]};
    last_d = (cnt_q == CNT_W'(WIDTH - 1));
  end

  // On the MSB edge c_q is the carry into the MSB and c_d the carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b_c;
            c_q     <= bus.cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          c_q   <= c_d;
          res_q <= res_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_d) begin
            sum_q   <= res_d;
            cout_q  <= c_d;
            ovf_q   <= c_q ^ c_d;
            zero_q  <= (res_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
  assign bus.zero = zero_q;
endmodule

// File: tb/tb_serial_addsub4.sv
// Directed and random checks of serial_addsub4 against an arithmetic reference.
module tb_serial_addsub4;
  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   vec;
  int   errs;

  serial_addsub4_if #(.WIDTH(W)) bus ();

  serial_addsub4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result from plain arithmetic: unsigned for carry, signed range for overflow.
  task automatic model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       output logic [W-1:0] es, output logic ec, output logic eo,
                       output logic ez);
    int u;
    int s;
    u  = int'(ta) + int'(tb) + int'(tc);
    s  = int'($signed(ta)) + int'($signed(tb)) + int'(tc);
    es = u[W-1:0];
    ec = (u >= (1 << W));
    eo = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
    ez = (es == '0);
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] es, input logic ec,
                            input logic eo, input logic ez);
    check({tag, ".sum"},  32'(bus.sum),  32'(es));
    check({tag, ".cout"}, 32'(bus.cout), 32'(ec));
    check({tag, ".ovf"},  32'(bus.ovf),  32'(eo));
    check({tag, ".zero"}, 32'(bus.zero), 32'(ez));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input bit interfere);
    logic [W-1:0] es, hs;
    logic         ec, eo, ez, hc, ho, hz;
    model(ta, tb, tc, es, ec, eo, ez);
    hs = bus.sum; hc = bus.cout; ho = bus.ovf; hz = bus.zero;
    @(negedge clk);
    bus.start = 1'b1; bus.a = ta; bus.b_c = tb; bus.cin = tc;
    @(posedge clk); #1;
    check({tag, ".busy_k"}, 32'(bus.busy), 32'd1);
    check({tag, ".done_k"}, 32'(bus.done), 32'd0);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (interfere && i == 2) begin
        bus.start = 1'b1; bus.a = '1; bus.b_c = '1; bus.cin = 1'b1;
      end else begin
        bus.start = 1'b0;
        bus.a = W'($urandom); bus.b_c = W'($urandom); bus.cin = 1'($urandom);
      end
      @(posedge clk); #1;
      if (i < W) begin
        check({tag, ".busy_mid"}, 32'(bus.busy), 32'd1);
        check({tag, ".done_mid"}, 32'(bus.done), 32'd0);
        check_outs({tag, ".hold_mid"}, hs, hc, ho, hz);
      end else begin
        check({tag, ".busy_end"}, 32'(bus.busy), 32'd0);
        check({tag, ".done_end"}, 32'(bus.done), 32'd1);
        check_outs({tag, ".res"}, es, ec, eo, ez);
      end
    end
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk); #1;
    check({tag, ".done_off"}, 32'(bus.done), 32'd0);
    check({tag, ".busy_off"}, 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, ".idle_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    logic [W-1:0] es;
    logic         ec, eo, ez;
    vec = 0; errs = 0;
    bus.start = 1'b0; bus.a = '0; bus.b_c = '0; bus.cin = 1'b0;
    rst_n = 1'b0;
    #2;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check_outs("rst", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    run_op("add",  4'b0100, 4'b0011, 1'b0, 1'b0);
    check_outs("add.abs", 4'b0111, 1'b0, 1'b0, 1'b0);
    run_op("sub44", 4'b0100, 4'b1011, 1'b1, 1'b0);
    check_outs("sub44.abs", 4'b0000, 1'b1, 1'b0, 1'b1);
    run_op("ovfp", 4'b0111, 4'b0001, 1'b0, 1'b0);
    check_outs("ovfp.abs", 4'b1000, 1'b0, 1'b1, 1'b0);
    run_op("ovfn", 4'b1000, 4'b1110, 1'b1, 1'b0);
    check_outs("ovfn.abs", 4'b0111, 1'b1, 1'b1, 1'b0);

    // Second start lands in SHIFT; run_op also confirms no follow-on operation.
    run_op("busystart", 4'b0010, 4'b0011, 1'b0, 1'b1);
    check_outs("busystart.abs", 4'b0101, 1'b0, 1'b0, 1'b0);

    // Result hold while inputs wiggle with start low.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.a = W'($urandom); bus.b_c = W'($urandom); bus.cin = 1'($urandom);
      @(posedge clk); #1;
      check("hold.done", 32'(bus.done), 32'd0);
      check_outs("hold", 4'b0101, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 4'b0110; bus.b_c = 4'b0101; bus.cin = 1'b0;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", 32'(bus.busy), 32'd0);
    check("midrst.done", 32'(bus.done), 32'd0);
    check_outs("midrst", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      check("postrst.done", 32'(bus.done), 32'd0);
      check("postrst.busy", 32'(bus.busy), 32'd0);
    end
    run_op("fresh", 4'b0110, 4'b0101, 1'b0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      run_op("rand", ra, rb, rc, 1'b0);
      model(ra, rb, rc, es, ec, eo, ez);
      check_outs("rand.after", es, ec, eo, ez);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
